// File: rtl/seq_multiplier_8bit.sv
// -----------------------------------------------------------------------------
// seq_multiplier_8bit
//
// Unsigned shift-add multiplier that sits behind the two 8-bit operand
// registers. A Start pulse (accepted in IDLE or DONE) captures inA/inB.
// WIDTH add/shift iterations then follow, and the full 2*WIDTH-bit product
// is registered on the last one. Done pulses for one cycle while the new
// product is presented, so it can drive the Load of the result register pair.
//
// Ports
//   Clock      in   1        rising-edge clock
//   Clear      in   1        synchronous active-high reset, overrides all inputs
//   Start      in   1        multiply request, sampled only in IDLE or DONE
//   inA        in   WIDTH    multiplicand, captured on the accepting edge
//   inB        in   WIDTH    multiplier, captured on the accepting edge
//   outProduct out  2*WIDTH  registered product, held between completions
//   Busy       out  1        high while iterating (CALC)
//   Done       out  1        one-cycle pulse when outProduct has just updated
// -----------------------------------------------------------------------------
module seq_multiplier_8bit #(
    parameter int WIDTH = 8
) (
    input  logic                 Clock,
    input  logic                 Clear,
    input  logic                 Start,
    input  logic [WIDTH-1:0]     inA,
    input  logic [WIDTH-1:0]     inB,
    output logic [2*WIDTH-1:0]   outProduct,
    output logic                 Busy,
    output logic                 Done
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [PW-1:0]     r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [PW-1:0]     r_acc;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     r_product;
    logic              r_busy;
    logic              r_done;

    logic              w_accept;
    logic              w_last_iter;
    logic [PW-1:0]     w_acc_sum;
    logic              w_busy_nxt;
    logic              w_done_nxt;

    // Start is only honoured outside CALC; an illegal state encoding is
    // treated as not accepting, and the next-state logic recovers it to IDLE.
    assign w_accept    = ((r_state == IDLE) || (r_state == DONE)) && Start;
    assign w_last_iter = (r_state == CALC) && (r_count == LAST_COUNT);

    // Accumulator value after this iteration's conditional add. Truncation
    // to PW bits is safe because the product of two WIDTH-bit values fits.
    assign w_acc_sum = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // State register
    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = IDLE;
        case (r_state)
            IDLE: w_next_state = Start ? CALC : IDLE;
            CALC: w_next_state = (r_count == LAST_COUNT) ? DONE : CALC;
            DONE: w_next_state = Start ? CALC : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Output decode: Busy/Done are registered from the state being entered,
    // so they line up with the state and carry no input-to-output path.
    always_comb begin
        w_busy_nxt = (w_next_state == CALC);
        w_done_nxt = (w_next_state == DONE);
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Shift-add datapath. Operands are captured only on the accepting edge,
    // so later changes on inA/inB cannot disturb an operation in flight.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (w_accept) begin
            r_mcand  <= {{WIDTH{1'b0}}, inA};
            r_mplier <= inB;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (r_state == CALC) begin
            r_acc    <= w_acc_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 1'b1;
        end
    end

    // Result register: changes only on Clear or on the completing edge,
    // and takes the accumulator including the final iteration's add.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_product <= '0;
        end else if (w_last_iter) begin
            r_product <= w_acc_sum;
        end
    end

    assign outProduct = r_product;
    assign Busy       = r_busy;
    assign Done       = r_done;

endmodule

// File: tb/tb_seq_multiplier_8bit.sv
// -----------------------------------------------------------------------------
// tb_seq_multiplier_8bit
//
// Scoreboard bench for seq_multiplier_8bit. A request-level model watches the
// inputs at each rising edge: an accepted Start pushes {a*b, due cycle} into a
// queue. A separate monitor, sampling 1 time unit after each edge, checks
// Busy, Done timing, the product on each Done and that outProduct holds.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_multiplier_8bit;

    localparam int W = 8;

    logic           Clock;
    logic           Clear;
    logic           Start;
    logic [W-1:0]   inA;
    logic [W-1:0]   inB;
    logic [2*W-1:0] outProduct;
    logic           Busy;
    logic           Done;

    seq_multiplier_8bit #(.WIDTH(W)) dut (
        .Clock      (Clock),
        .Clear      (Clear),
        .Start      (Start),
        .inA        (inA),
        .inB        (inB),
        .outProduct (outProduct),
        .Busy       (Busy),
        .Done       (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [2*W-1:0] prod;
        int             due;
    } exp_t;

    exp_t q[$];

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int rem = 0;          // edges until the current operation completes
    bit saw_clear = 0;
    bit armed = 0;        // checking starts once the first Clear has been seen
    logic [2*W-1:0] held = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Request-level model: a multiply takes W edges after acceptance, and a
    // new request can be taken on any edge where none is outstanding.
    always @(posedge Clock) begin
        cyc++;
        if (Clear) begin
            saw_clear = 1;
            armed     = 1;
            rem       = 0;
        end else begin
            saw_clear = 0;
            if (rem > 0) begin
                rem--;
            end else if (Start) begin
                exp_t e;
                e.prod = 16'(int'(inA) * int'(inB));
                e.due  = cyc + W;
                q.push_back(e);
                rem = W;
            end
        end
    end

    // Monitor
    always @(posedge Clock) begin
        #1;
        if (armed) begin
            bit exp_done;
            if (saw_clear) begin
                q.delete();
                held = '0;
            end
            exp_done = (q.size() > 0) && (q[0].due == cyc);
            chk("done", 32'(Done), 32'(exp_done));
            chk("busy", 32'(Busy), 32'(rem > 0));
            if (Done || exp_done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", 32'(1), 32'(0));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (Done) chk("product", 32'(outProduct), 32'(e.prod));
                    held = e.prod;
                end
            end
            chk("hold", 32'(outProduct), 32'(held));
        end
    end

    task automatic step(input bit clr, input bit st, input int a, input int b);
        @(negedge Clock);
        Clear = clr;
        Start = st;
        inA   = W'(a);
        inB   = W'(b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, $urandom_range(0, 255), $urandom_range(0, 255));
    endtask

    task automatic one_op(input int a, input int b);
        step(0, 1, a, b);
        idle(W + 2);
    endtask

    initial begin
        Clear = 1'b0;
        Start = 1'b0;
        inA   = '0;
        inB   = '0;

        // Reset with Start asserted: must be ignored
        step(1, 1, 7, 9);
        step(1, 1, 7, 9);
        idle(2);

        // Basic multiply, operands change right after acceptance
        step(0, 1, 5, 10);
        for (int i = 0; i < W + 3; i++) step(0, 0, 3, 3);

        // Extremes
        one_op(255, 255);
        one_op(0, 200);
        one_op(1, 255);

        // Start during CALC is ignored
        step(0, 1, 12, 12);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 2, 2);
        idle(W + 2);

        // Clear mid-operation, then a fresh multiply
        step(0, 1, 100, 3);
        idle(3);
        step(1, 0, 0, 0);
        idle(2);
        one_op(6, 7);

        // Back-to-back with Start held high, operands switched during CALC
        for (int i = 0; i < 4; i++) step(0, 1, 4, 5);
        for (int i = 0; i < 9; i++) step(0, 1, 9, 9);
        idle(W + 4);

        // Randomised traffic, including occasional Clear and extreme operands
        for (int i = 0; i < 400; i++) begin
            int a, b;
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            if ($urandom_range(0, 9) == 0) a = 255;
            if ($urandom_range(0, 9) == 0) b = 0;
            step($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0, a, b);
        end

        // Drain outstanding operations within a bounded number of cycles
        Start = 1'b0;
        Clear = 1'b0;
        for (int i = 0; i < 3 * W && q.size() > 0; i++) @(negedge Clock);
        @(negedge Clock);
        chk("drain", 32'(q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_multiplier_8bit.md
Name: seq_multiplier_8bit

Overview:
Unsigned shift-add multiplier directly downstream of the 8-bit operand registers in the datapath. It consumes two registered 8-bit values (outData of two Register_8bit instances) on a Start pulse. It produces a 16-bit product after a fixed number of cycles, then signals completion with a one-cycle Done pulse. Done is suitable as the Load of the result register pair.

Parameters:
WIDTH, 8, operand width in bits; product width is 2*WIDTH; iteration count is WIDTH.

Ports:
Clock  input  1  system clock; all state updates on the rising edge.
Clear  input  1  reset; synchronous, active-high; overrides every other input.
Start  input  1  request a multiply; sampled only when state is IDLE or DONE.
inA  input  WIDTH  multiplicand, captured on the accepting edge only.
inB  input  WIDTH  multiplier, captured on the accepting edge only.
outProduct  output  2*WIDTH  registered product; held between completions.
Busy  output  1  high while in CALC.
Done  output  1  one-cycle pulse while in DONE, when outProduct has just updated.

Behaviour:
- States: IDLE, CALC, DONE. All outputs are registered. There is no combinational path from any input to any output.
- Clear=1 at an edge has the following effect, regardless of state or Start:
  - state goes to IDLE;
  - outProduct=0, Busy=0, Done=0;
  - internal accumulator, shift registers and counter go to 0.
- Clear mid-CALC aborts the operation. No Done is produced and outProduct is forced to 0.
- Accepting a Start (edge E0, state IDLE or DONE, Start=1, Clear=0):
  - mcand is loaded with inA zero-extended to 2*WIDTH;
  - mplier is loaded with inB;
  - acc=0, count=0;
  - state goes to CALC and Busy=1 from E0.
- CALC iteration (edges E1..E_WIDTH), in this order:
  - if mplier[0]=1 then acc = acc + mcand, truncated to 2*WIDTH bits (overflow is impossible);
  - mcand is shifted left by 1;
  - mplier is shifted right by 1 (logical);
  - count increments.
- On the edge where count==WIDTH-1 (E_WIDTH):
  - outProduct takes the final acc value, including this last add;
  - state goes to DONE, Done=1, Busy=0.
- Latency: Start accepted at E0 gives Done high in the cycle after E_WIDTH, i.e. WIDTH edges after acceptance (8 for the default).
- DONE lasts exactly one cycle:
  - next edge with Start=0: go to IDLE, Done=0;
  - next edge with Start=1: accept new operands (back-to-back), go to CALC, Done=0, Busy=1.
- Start in CALC is ignored. Operands and count are unaffected, and no request is queued.
- inA and inB may change freely after the accepting edge without affecting the result.
- outProduct changes only on Clear or on the completing edge.
- Arithmetic is unsigned. 0*x gives 0, and the full WIDTH iterations still run with unchanged latency. Maximum result is (2^WIDTH-1)^2 = 65025 for WIDTH=8.
- Start held high continuously gives repeated operations every WIDTH+1 cycles, with a Done pulse for each.

Test Plan:
1. Reset: Clear=1 for 2 edges, Start=1, inA=7, inB=9 -> outProduct=0, Busy=0, Done=0 throughout. Start is ignored while Clear=1.
2. Basic multiply: Start pulse for one edge with inA=5, inB=10, then inputs changed to 3/3 -> Busy high for 8 cycles. Done high for exactly one cycle, 8 edges after acceptance, with outProduct=50. Value holds afterward.
3. Extremes: 255*255 gives 65025 (16'hFE01); 0*200 gives 0; 1*255 gives 255. Each has Done at the same 8-edge latency.
4. Start during CALC: accept 12*12, then pulse Start with inA=2, inB=2 at edge E3 -> ignored. Result 144, and a single Done pulse.
5. Clear mid-operation: accept 100*3, assert Clear at E4 -> IDLE, Busy=0, outProduct=0, no Done. A following Start with 6*7 completes with 42.
6. Back-to-back: Start held high with inA=4, inB=5, switching to 9/9 during CALC -> first Done gives 20. Second op is accepted on the DONE edge; its Done comes 9 cycles after the first Done and gives 81.
